// File: rtl/dsr_align_seq_pkg.sv
// Shared constants for the DSR alignment sequencer: default parameters,
// FSM state codes and a small constant-function helper.
package dsr_align_pkg;

  localparam int unsigned NCH_DEF      = 8;
  localparam int unsigned W_DEF        = 12;
  localparam int unsigned RST_LEN_DEF  = 7;
  localparam int unsigned SETTLE_DEF   = 5;
  localparam int unsigned CHK_LEN_DEF  = 4;
  localparam int unsigned MAX_SLIP_DEF = 12;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RST_DSR   = 3'd1;
  localparam logic [2:0] S_RST_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK     = 3'd3;
  localparam logic [2:0] S_SLIP      = 3'd4;
  localparam logic [2:0] S_SLIP_WAIT = 3'd5;
  localparam logic [2:0] S_NEXT      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dsr_align_seq_if.sv
// Handshake/data bundle between the deserializer bank and the alignment
// sequencer. master = controller/bench side, slave = sequencer side.
//   START, TRAIN_PAT, DIN            : into the sequencer
//   DSR_RST, BIT_SLIP, CH_ALIGNED,
//   CH_FAIL, ALL_ALIGNED, BUSY       : out of the sequencer
interface dsr_align_seq_if #(
  parameter int unsigned NCH = dsr_align_pkg::NCH_DEF,
  parameter int unsigned W   = dsr_align_pkg::W_DEF
);
  logic             START;
  logic [W-1:0]     TRAIN_PAT;
  logic [NCH*W-1:0] DIN;
  logic             DSR_RST;
  logic [NCH-1:0]   BIT_SLIP;
  logic [NCH-1:0]   CH_ALIGNED;
  logic [NCH-1:0]   CH_FAIL;
  logic             ALL_ALIGNED;
  logic             BUSY;

  modport master (
    output START, TRAIN_PAT, DIN,
    input  DSR_RST, BIT_SLIP, CH_ALIGNED, CH_FAIL, ALL_ALIGNED, BUSY
  );

  modport slave (
    input  START, TRAIN_PAT, DIN,
    output DSR_RST, BIT_SLIP, CH_ALIGNED, CH_FAIL, ALL_ALIGNED, BUSY
  );
endinterface

// File: rtl/dsr_align_seq_word_mux.sv
// Registered NCH:1 word select: word_q holds DIN[sel] from the previous cycle.
//   clk, rst_n : clock, async active-low reset
//   din        : NCH packed words, channel c at din[c*W +: W]
//   sel        : channel index
//   word_q     : selected word, one cycle latency
module dsr_word_mux #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned W     = 12,
  parameter int unsigned SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] din,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     word_q
);
  logic [W-1:0] word_d;

  always_comb begin
    word_d = din[32'(sel) * W +: W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end
endmodule

// File: rtl/dsr_align_seq.sv
// Training-pattern alignment sequencer for a bank of NCH deserializers.
// Pulses a shared DSR reset, then walks the channels one at a time, issuing
// single-cycle bit slips until CHK_LEN consecutive words match TRAIN_PAT or
// MAX_SLIP slips are spent. All outputs are registered from the next state.
//   CLK, RST_B : clock, async active-low reset
//   bus        : dsr_align_seq_if slave (START/TRAIN_PAT/DIN in, flags out)
// Optional macro DSR_ALIGN_MON_EN: keep comparing every channel in DONE and
// drop a channel's aligned flag after CHK_LEN consecutive mismatches.
module dsr_align_seq
  import dsr_align_pkg::*;
#(
  parameter int unsigned NCH      = NCH_DEF,
  parameter int unsigned W        = W_DEF,
  parameter int unsigned RST_LEN  = RST_LEN_DEF,
  parameter int unsigned SETTLE   = SETTLE_DEF,
  parameter int unsigned CHK_LEN  = CHK_LEN_DEF,
  parameter int unsigned MAX_SLIP = MAX_SLIP_DEF
) (
  input logic           CLK,
  input logic           RST_B,
  dsr_align_seq_if.slave bus
);
  localparam int unsigned WC_W = max_u(3, $clog2(max_u(RST_LEN, SETTLE) + 1));
  localparam int unsigned SC_W = $clog2(MAX_SLIP + 1);
  localparam int unsigned MC_W = $clog2(CHK_LEN + 1);
  localparam int unsigned CI_W = $clog2(NCH);

  logic [2:0]      state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [SC_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [MC_W-1:0] mcnt_q, mcnt_d;
  logic [CI_W-1:0] ch_idx_q, ch_idx_d;
  logic [NCH-1:0]  ch_aligned_q, ch_aligned_d;
  logic [NCH-1:0]  ch_fail_q, ch_fail_d;
  logic [NCH-1:0]  bit_slip_q, bit_slip_d;
  logic            dsr_rst_q, dsr_rst_d;
  logic            all_aligned_q, all_aligned_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    word_q;

`ifdef DSR_ALIGN_MON_EN
  logic [NCH-1:0][MC_W-1:0] mon_cnt_q, mon_cnt_d;
`endif

  // Word under test for the current channel (one-cycle latency, hidden by SETTLE)
  dsr_word_mux #(.NCH(NCH), .W(W), .SEL_W(CI_W)) u_word_mux (
    .clk    (CLK),
    .rst_n  (RST_B),
    .din    (bus.DIN),
    .sel    (ch_idx_q),
    .word_q (word_q)
  );

  // Next-state, counter and flag logic
  always_comb begin
    state_d      = state_q;
    wcnt_d       = '0;
    slip_cnt_d   = slip_cnt_q;
    mcnt_d       = mcnt_q;
    ch_idx_d     = ch_idx_q;
    ch_aligned_d = ch_aligned_q;
    ch_fail_d    = ch_fail_q;
`ifdef DSR_ALIGN_MON_EN
    mon_cnt_d    = '0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          state_d      = S_RST_DSR;
          ch_idx_d     = '0;
          slip_cnt_d   = '0;
          mcnt_d       = '0;
          ch_aligned_d = '0;
          ch_fail_d    = '0;
        end
      end
      S_RST_DSR: begin
        wcnt_d = wcnt_q + WC_W'(1);
        if (wcnt_q == WC_W'(RST_LEN - 1)) state_d = S_RST_WAIT;
      end
      S_RST_WAIT, S_SLIP_WAIT: begin
        wcnt_d = wcnt_q + WC_W'(1);
        mcnt_d = '0;
        if (wcnt_q == WC_W'(SETTLE - 1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (word_q == bus.TRAIN_PAT) begin
          mcnt_d = mcnt_q + MC_W'(1);
          if (mcnt_q == MC_W'(CHK_LEN - 1)) begin
            ch_aligned_d[ch_idx_q] = 1'b1;
            state_d                = S_NEXT;
          end
        end else begin
          mcnt_d = '0;
          if (slip_cnt_q == SC_W'(MAX_SLIP)) begin
            ch_fail_d[ch_idx_q] = 1'b1;
            state_d             = S_NEXT;
          end else begin
            state_d = S_SLIP;
          end
        end
      end
      S_SLIP: begin
        slip_cnt_d = slip_cnt_q + SC_W'(1);
        state_d    = S_SLIP_WAIT;
      end
      S_NEXT: begin
        slip_cnt_d = '0;
        mcnt_d     = '0;
        if (ch_idx_q == CI_W'(NCH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_idx_d = ch_idx_q + CI_W'(1);
          state_d  = S_RST_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dwell counter restarts on every state change
    if (state_d != state_q) wcnt_d = '0;

`ifdef DSR_ALIGN_MON_EN
    // Post-alignment watch: count consecutive mismatches per channel
    if (state_q == S_DONE && state_d == S_DONE) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (bus.DIN[c*W +: W] != bus.TRAIN_PAT) begin
          if (mon_cnt_q[c] >= MC_W'(CHK_LEN - 1)) begin
            ch_aligned_d[c] = 1'b0;
            mon_cnt_d[c]    = MC_W'(CHK_LEN);
          end else begin
            mon_cnt_d[c] = mon_cnt_q[c] + MC_W'(1);
          end
        end
      end
    end
`endif

    // Registered outputs decoded from the next state
    dsr_rst_d     = (state_d == S_RST_DSR);
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
    bit_slip_d    = (state_d == S_SLIP) ? (NCH'(1) << ch_idx_d) : '0;
    all_aligned_d = (state_q == S_DONE) && (state_d == S_DONE) &&
                    (&ch_aligned_d) && !(|ch_fail_d);
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q       <= S_IDLE;
      wcnt_q        <= '0;
      slip_cnt_q    <= '0;
      mcnt_q        <= '0;
      ch_idx_q      <= '0;
      ch_aligned_q  <= '0;
      ch_fail_q     <= '0;
      bit_slip_q    <= '0;
      dsr_rst_q     <= 1'b0;
      all_aligned_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      slip_cnt_q    <= slip_cnt_d;
      mcnt_q        <= mcnt_d;
      ch_idx_q      <= ch_idx_d;
      ch_aligned_q  <= ch_aligned_d;
      ch_fail_q     <= ch_fail_d;
      bit_slip_q    <= bit_slip_d;
      dsr_rst_q     <= dsr_rst_d;
      all_aligned_q <= all_aligned_d;
      busy_q        <= busy_d;
    end
  end

`ifdef DSR_ALIGN_MON_EN
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) mon_cnt_q <= '0;
    else        mon_cnt_q <= mon_cnt_d;
  end
`endif

  assign bus.DSR_RST     = dsr_rst_q;
  assign bus.BIT_SLIP    = bit_slip_q;
  assign bus.CH_ALIGNED  = ch_aligned_q;
  assign bus.CH_FAIL     = ch_fail_q;
  assign bus.ALL_ALIGNED = all_aligned_q;
  assign bus.BUSY        = busy_q;
endmodule

// File: tb/tb_dsr_align_seq.sv
// Bench for dsr_align_seq: a deserializer model reacts to DSR_RST/BIT_SLIP,
// and a phase-level model of the alignment pass predicts every output cycle.
module tb_dsr_align_seq;
  import dsr_align_pkg::*;

  localparam int unsigned NCH      = 8;
  localparam int unsigned W        = 12;
  localparam int unsigned RST_LEN  = 7;
  localparam int unsigned SETTLE   = 5;
  localparam int unsigned CHK_LEN  = 4;
  localparam int unsigned MAX_SLIP = 12;
  localparam int          NEVER    = 99;
`ifdef DSR_ALIGN_MON_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  typedef struct packed {
    logic           dsr;
    logic [NCH-1:0] slip;
    logic [NCH-1:0] al;
    logic [NCH-1:0] fail;
    logic           all;
    logic           busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dsr_align_seq_if #(.NCH(NCH), .W(W)) bus ();

  dsr_align_seq #(
    .NCH(NCH), .W(W), .RST_LEN(RST_LEN), .SETTLE(SETTLE),
    .CHK_LEN(CHK_LEN), .MAX_SLIP(MAX_SLIP)
  ) dut (
    .CLK   (clk),
    .RST_B (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] pat;
  int   need[NCH];
  int   ds_slips[NCH];
  int   gch, gtime;
  int   corrupt_ch;
  bit   corrupt_on;
  exp_t trace[$];
  logic [NCH-1:0] m_al, m_fail;

  int obs_dsr;
  int obs_slip[NCH];
  int last_slip[NCH];
  int min_gap[NCH];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t cur_out();
    exp_t e;
    e = {bus.DSR_RST, bus.BIT_SLIP, bus.CH_ALIGNED, bus.CH_FAIL, bus.ALL_ALIGNED, bus.BUSY};
    return e;
  endfunction

  // Deserializer model: a channel shows the pattern once it has had enough slips
  task automatic drive_din(input int t);
    logic [W-1:0] w;
    bit ok;
    for (int c = 0; c < NCH; c++) begin
      ok = (ds_slips[c] >= need[c]);
      if (c == gch && t == gtime) ok = 0;
      if (corrupt_on && c == corrupt_ch) ok = 0;
      w = ok ? pat : (pat ^ W'(c + 1));
      bus.DIN[c*W +: W] = w;
    end
  endtask

  function automatic void push_n(input int n, input logic dsr, input logic [NCH-1:0] slip,
                                 input logic busy, input logic allf);
    exp_t e;
    e.dsr = dsr; e.slip = slip; e.al = m_al; e.fail = m_fail; e.all = allf; e.busy = busy;
    for (int i = 0; i < n; i++) trace.push_back(e);
  endfunction

  // Word seen by a check in cycle t was on DIN during cycle t-1
  function automatic bit sees_pat(input int c, input int slips, input int t);
    return (slips >= need[c]) && !(c == gch && (t - 1) == gtime);
  endfunction

  // Expected output per cycle of a pass, walked phase by phase
  function automatic void build_trace();
    int slips, run;
    bit fin, ok;
    logic [NCH-1:0] one;
    trace.delete();
    m_al = '0; m_fail = '0;
    push_n(RST_LEN, 1'b1, '0, 1'b1, 1'b0);
    for (int c = 0; c < NCH; c++) begin
      one = NCH'(1) << c;
      push_n(SETTLE, 1'b0, '0, 1'b1, 1'b0);
      slips = 0; run = 0; fin = 0;
      while (!fin) begin
        ok = sees_pat(c, slips, trace.size());
        push_n(1, 1'b0, '0, 1'b1, 1'b0);
        if (ok) begin
          run++;
          if (run == int'(CHK_LEN)) begin
            m_al[c] = 1'b1;
            push_n(1, 1'b0, '0, 1'b1, 1'b0);
            fin = 1;
          end
        end else begin
          run = 0;
          if (slips == int'(MAX_SLIP)) begin
            m_fail[c] = 1'b1;
            push_n(1, 1'b0, '0, 1'b1, 1'b0);
            fin = 1;
          end else begin
            push_n(1, 1'b0, one, 1'b1, 1'b0);
            slips++;
            push_n(SETTLE, 1'b0, '0, 1'b1, 1'b0);
          end
        end
      end
    end
    push_n(1, 1'b0, '0, 1'b0, 1'b0);
    push_n(3, 1'b0, '0, 1'b0, (&m_al) && (m_fail == '0));
  endfunction

  // Run one pass from START, comparing every cycle; optionally stop early
  task automatic run_pass(input int stop_at, input bit noise);
    exp_t cur;
    int n;
    build_trace();
    n = trace.size();
    obs_dsr = 0;
    for (int c = 0; c < NCH; c++) begin
      ds_slips[c] = 0; obs_slip[c] = 0; last_slip[c] = -1; min_gap[c] = 1000;
    end
    bus.START = 1'b1;
    drive_din(-1);
    @(negedge clk);
    bus.START = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (t == stop_at) return;
      cur = cur_out();
      check($sformatf("cycle%0d", t), 64'(cur), 64'(trace[t]));
      check($sformatf("excl%0d", t),
            64'(($countones(cur.slip) <= 1) && !(cur.dsr && (|cur.slip))), 64'(1));
      if (cur.dsr) begin
        obs_dsr++;
        for (int c = 0; c < NCH; c++) ds_slips[c] = 0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (cur.slip[c]) begin
          ds_slips[c]++;
          obs_slip[c]++;
          if (last_slip[c] >= 0 && (t - last_slip[c]) < min_gap[c]) min_gap[c] = t - last_slip[c];
          last_slip[c] = t;
        end
      end
      bus.START = noise && (t < n - 4) && ($urandom_range(0, 7) == 0);
      drive_din(t);
      @(negedge clk);
    end
    bus.START = 1'b0;
  endtask

  function automatic int sum_slips_except(input int skip);
    int s = 0;
    for (int c = 0; c < NCH; c++) if (c != skip) s += obs_slip[c];
    return s;
  endfunction

  function automatic void set_need(input int v);
    for (int c = 0; c < NCH; c++) need[c] = v;
  endfunction

  // Corrupt channel 1 for len cycles while in DONE and watch the flags
  task automatic mon_burst(input int len);
    bit cleared;
    corrupt_ch = 1;
    for (int j = 0; j < len + 3; j++) begin
      corrupt_on = (j < len);
      drive_din(-1);
      @(negedge clk);
      cleared = MON_EN && (len >= int'(CHK_LEN)) && ((j + 1) >= int'(CHK_LEN));
      check($sformatf("mon%0d_al_j%0d", len, j), 64'(bus.CH_ALIGNED),
            cleared ? 64'h0FD : 64'h0FF);
      check($sformatf("mon%0d_all_j%0d", len, j), 64'(bus.ALL_ALIGNED), cleared ? 64'd0 : 64'd1);
    end
    corrupt_on = 0;
    drive_din(-1);
  endtask

  initial begin
    int stop;
    rst_n = 1'b0;
    bus.START = 1'b0;
    pat = 12'hF0F;
    bus.TRAIN_PAT = pat;
    set_need(0);
    gch = -1; gtime = -1; corrupt_ch = 1; corrupt_on = 0;
    for (int c = 0; c < NCH; c++) ds_slips[c] = 0;
    drive_din(-1);
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(cur_out()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", 64'(cur_out()), 64'd0);

    // 1: everything already aligned
    run_pass(-1, 0);
    check("t1_dsr_cycles", 64'(obs_dsr), 64'd7);
    check("t1_slips", 64'(sum_slips_except(-1)), 64'd0);
    check("t1_aligned", 64'(bus.CH_ALIGNED), 64'hFF);
    check("t1_all", 64'(bus.ALL_ALIGNED), 64'd1);
    check("t1_busy", 64'(bus.BUSY), 64'd0);

    // 2: channel 3 needs five slips
    set_need(0); need[3] = 5;
    run_pass(-1, 0);
    check("t2_slips_ch3", 64'(obs_slip[3]), 64'd5);
    check("t2_slips_other", 64'(sum_slips_except(3)), 64'd0);
    check("t2_gap", 64'(min_gap[3]), 64'd7);
    check("t2_aligned", 64'(bus.CH_ALIGNED), 64'hFF);

    // 3: channel 6 never locks
    set_need(0); need[6] = NEVER;
    run_pass(-1, 0);
    check("t3_slips_ch6", 64'(obs_slip[6]), 64'd12);
    check("t3_fail", 64'(bus.CH_FAIL), 64'h40);
    check("t3_aligned", 64'(bus.CH_ALIGNED), 64'hBF);
    check("t3_all", 64'(bus.ALL_ALIGNED), 64'd0);

    // 4: channel 0 glitches on its fourth check word
    set_need(0); gch = 0; gtime = 14;
    run_pass(-1, 0);
    check("t4_slips_ch0", 64'(obs_slip[0]), 64'd1);
    check("t4_aligned", 64'(bus.CH_ALIGNED), 64'hFF);
    gch = -1; gtime = -1;

    // 5: reset during SLIP_WAIT of channel 2
    set_need(0); need[2] = 3;
    build_trace();
    stop = -1;
    for (int i = 0; i < trace.size(); i++) if (stop < 0 && trace[i].slip[2]) stop = i + 2;
    run_pass(stop, 0);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset", 64'(cur_out()), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("t5_in_reset", 64'(cur_out()), 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t5_idle", 64'(cur_out()), 64'd0);
    end
    set_need(0);
    run_pass(-1, 0);
    check("t5_clean_aligned", 64'(bus.CH_ALIGNED), 64'hFF);

    // 6: corruption while in DONE
    mon_burst(3);
    mon_burst(4);

    // Randomized passes: random pattern, random slip needs, START noise
    for (int p = 0; p < 5; p++) begin
      pat = W'($urandom);
      bus.TRAIN_PAT = pat;
      for (int c = 0; c < NCH; c++) need[c] = int'($urandom_range(0, 14));
      run_pass(-1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
